// File: rtl/bram_rmw_updater.sv
// Read-modify-write front end for a true dual-port weight BRAM: port A reads,
// port B writes saturated sums or clear words, with one-deep write forwarding.
`timescale 1ns/1ps
module bram_rmw_updater #(
    parameter int unsigned    AW         = 10,
    parameter int unsigned    DW         = 16,
    parameter logic [DW-1:0]  INIT_VALUE = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_delta,
    output logic          wea,
    output logic [AW-1:0] addra,
    output logic [DW-1:0] dia,
    input  logic [DW-1:0] doa,
    output logic          web,
    output logic [AW-1:0] addrb,
    output logic [DW-1:0] dib,
    output logic          upd_valid,
    output logic [AW-1:0] upd_addr,
    output logic [DW-1:0] upd_data,
    output logic          upd_sat,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    // Returns {clamped, result}; the top two sum bits disagree only on overflow.
    function automatic logic [DW:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] sum;
        sum = {a[DW-1], a} + {b[DW-1], b};
        if (sum[DW] != sum[DW-1]) begin
            if (sum[DW]) begin
                sat_add = {1'b1, 1'b1, {(DW-1){1'b0}}};
            end else begin
                sat_add = {1'b1, 1'b0, {(DW-1){1'b1}}};
            end
        end else begin
            sat_add = {1'b0, sum[DW-1:0]};
        end
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          s1_v_q, s2_v_q;
    logic [AW-1:0] s1_addr_q, s2_addr_q;
    logic [DW-1:0] s1_delta_q, s2_delta_q;
    logic          fwd_v_q;
    logic [AW-1:0] fwd_addr_q;
    logic [DW-1:0] fwd_data_q;

    logic          in_ready_s;
    logic          accept_s;
    logic          web_s;
    logic          pipe_wr_s;
    logic [AW-1:0] addrb_s;
    logic [DW-1:0] dib_s;
    logic          sat_s;
    logic          fwd_hit_s;
    logic [DW-1:0] old_s;
    logic [DW:0]   sum_s;

    assign fwd_hit_s = fwd_v_q && (fwd_addr_q == s2_addr_q);
    assign old_s     = fwd_hit_s ? fwd_data_q : doa;
    assign sum_s     = sat_add(old_s, s2_delta_q);
    assign accept_s  = in_valid && in_ready_s;

    // Next-state logic and port B mux; port B belongs to CLEAR or to stage 2.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready_s = 1'b0;
        web_s      = 1'b0;
        pipe_wr_s  = 1'b0;
        addrb_s    = s2_addr_q;
        dib_s      = INIT_VALUE;
        sat_s      = 1'b0;
        case (state_q)
            ST_START: begin
                state_d = ST_CLEAR;
                cnt_d   = {AW{1'b0}};
            end
            ST_CLEAR: begin
                web_s   = 1'b1;
                addrb_s = cnt_q;
                dib_s   = INIT_VALUE;
                if (clr) begin
                    cnt_d = {AW{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = {AW{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                in_ready_s = !clr;
                web_s      = s2_v_q;
                pipe_wr_s  = s2_v_q;
                dib_s      = sum_s[DW-1:0];
                sat_s      = s2_v_q && sum_s[DW];
                if (clr) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                web_s     = s2_v_q;
                pipe_wr_s = s2_v_q;
                dib_s     = sum_s[DW-1:0];
                sat_s     = s2_v_q && sum_s[DW];
                if (!s1_v_q && !s2_v_q) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {AW{1'b0}};
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_START;
                cnt_d   = {AW{1'b0}};
            end
        endcase
    end

    // State, clear counter, two-stage request pipeline and forward register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_START;
            cnt_q      <= {AW{1'b0}};
            s1_v_q     <= 1'b0;
            s1_addr_q  <= {AW{1'b0}};
            s1_delta_q <= {DW{1'b0}};
            s2_v_q     <= 1'b0;
            s2_addr_q  <= {AW{1'b0}};
            s2_delta_q <= {DW{1'b0}};
            fwd_v_q    <= 1'b0;
            fwd_addr_q <= {AW{1'b0}};
            fwd_data_q <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_v_q     <= accept_s;
            s1_addr_q  <= accept_s ? in_addr : s1_addr_q;
            s1_delta_q <= accept_s ? in_delta : s1_delta_q;
            s2_v_q     <= s1_v_q;
            s2_addr_q  <= s1_addr_q;
            s2_delta_q <= s1_delta_q;
            fwd_v_q    <= pipe_wr_s;
            fwd_addr_q <= addrb_s;
            fwd_data_q <= dib_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign wea       = 1'b0;
    assign dia       = {DW{1'b0}};
    assign addra     = s1_addr_q;
    assign web       = web_s;
    assign addrb     = addrb_s;
    assign dib       = dib_s;
    assign upd_valid = web_s;
    assign upd_addr  = addrb_s;
    assign upd_data  = dib_s;
    assign upd_sat   = sat_s;
    assign busy      = (state_q != ST_RUN);

endmodule

// File: tb/tb_bram_rmw_updater.sv
// Bench for bram_rmw_updater: behavioural BRAM, per-address saturating model,
// directed scenarios and a randomized update stream.
`timescale 1ns/1ps
module tb_bram_rmw_updater;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset, clr, in_valid, in_ready;
    logic [9:0]  in_addr, addra, addrb, upd_addr;
    logic [15:0] in_delta, dia, doa, dib, upd_data;
    logic        wea, web, upd_valid, upd_sat, busy;

    bram_rmw_updater dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_delta(in_delta),
        .wea(wea), .addra(addra), .dia(dia), .doa(doa),
        .web(web), .addrb(addrb), .dib(dib),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
        .upd_sat(upd_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    // Read-first dual-port memory with one-cycle read latency.
    logic [15:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (wea) mem[addra] <= dia;
        if (web) mem[addrb] <= dib;
        doa <= mem[addra];
    end

    typedef struct {
        int          cyc;
        int          addr;
        logic [15:0] data;
        logic        sat;
    } wr_t;

    wr_t                wr_log[$];
    wr_t                exp_q[$];
    logic signed [15:0] ref_mem [0:DEPTH-1];
    int                 cyc = 0, total = 0, bad = 0, mon_err = 0;
    logic               obs_ready, obs_busy, obs_web, obs_sat, obs_wea;
    logic [9:0]         obs_addrb;
    logic [15:0]        obs_dib, obs_dia;
    logic [9:0]         b_addr [8];
    logic [15:0]        b_delta [8];

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'sd0;
        exp_q.delete();
    endtask

    task automatic drive_cycle(input logic v, input logic [9:0] a, input logic [15:0] d, input logic c);
        int s;
        wr_t w;
        logic signed [15:0] ds;
        in_valid = v; in_addr = a; in_delta = d; clr = c;
        @(negedge clk);
        obs_ready = in_ready; obs_busy = busy; obs_web = web; obs_sat = upd_sat;
        obs_wea = wea; obs_dia = dia; obs_addrb = addrb; obs_dib = dib;
        if (web === 1'b1) begin
            w.cyc = cyc; w.addr = int'(addrb); w.data = dib; w.sat = upd_sat;
            wr_log.push_back(w);
        end
        if (upd_valid !== web || upd_addr !== addrb || upd_data !== dib) mon_err++;
        if (web !== 1'b1 && upd_sat !== 1'b0) mon_err++;
        if (v && in_ready === 1'b1) begin
            ds = d;
            s = ref_mem[a] + ds;
            w.cyc = cyc + 2; w.addr = int'(a);
            w.sat = (s > 32767) || (s < -32768);
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            w.data = s[15:0];
            ref_mem[a] = s[15:0];
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 10'd0, 16'd0, 1'b0);
    endtask

    task automatic run_burst(input int n_req);
        for (int i = 0; i < n_req; i++) drive_cycle(1'b1, b_addr[i], b_delta[i], 1'b0);
        idle(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        total++;
        if (obs_web !== 1'b0 || obs_ready !== 1'b0 || obs_busy !== 1'b1 || obs_sat !== 1'b0 ||
            obs_wea !== 1'b0 || obs_dia !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: web=%b ready=%b busy=%b sat=%b wea=%b dia=%h, need 0 0 1 0 0 0000",
                     obs_web, obs_ready, obs_busy, obs_sat, obs_wea, obs_dia);
        end
        reset = 1'b0;
        clear_model();
        wr_log.delete();
        idle(1);
        total++;
        if (obs_web !== 1'b0 || obs_busy !== 1'b1) begin
            bad++;
            $display("FAIL start_cycle: web=%b busy=%b, need web=0 busy=1", obs_web, obs_busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle(1);
            total++;
            if (obs_web !== 1'b1 || obs_addrb !== 10'(i) || obs_dib !== 16'd0 || obs_sat !== 1'b0 || obs_ready !== 1'b0) begin
                bad++;
                $display("FAIL init_clear[%0d]: web=%b addrb=%0d dib=%h sat=%b ready=%b, need 1 %0d 0000 0 0",
                         i, obs_web, obs_addrb, obs_dib, obs_sat, obs_ready, i);
            end
        end
        idle(1);
        total++;
        if (obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_web !== 1'b0) begin
            bad++;
            $display("FAIL run_entry: ready=%b busy=%b web=%b, need 1 0 0", obs_ready, obs_busy, obs_web);
        end
    endtask

    task automatic test_single();
        int n;
        wr_log.delete();
        n = cyc;
        drive_cycle(1'b1, 10'd5, 16'd100, 1'b0);
        idle(4);
        total++;
        if (wr_log.size() != 1) begin
            bad++;
            $display("FAIL single_count: got %0d writes, need 1", wr_log.size());
        end else begin
            total++;
            if (wr_log[0].cyc != n + 2 || wr_log[0].addr != 5 || wr_log[0].data !== 16'd100 || wr_log[0].sat !== 1'b0) begin
                bad++;
                $display("FAIL single_write: cyc=%0d addr=%0d data=%h sat=%b, need cyc=%0d addr=5 data=0064 sat=0",
                         wr_log[0].cyc, wr_log[0].addr, wr_log[0].data, wr_log[0].sat, n + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [15:0] e_d [3];
        e_d[0] = 16'd10; e_d[1] = 16'd30; e_d[2] = 16'd60;
        b_addr[0] = 10'd7; b_addr[1] = 10'd7; b_addr[2] = 10'd7;
        b_delta[0] = 16'd10; b_delta[1] = 16'd20; b_delta[2] = 16'd30;
        wr_log.delete();
        n = cyc;
        run_burst(3);
        total++;
        if (wr_log.size() != 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d writes, need 3", wr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wr_log[i].cyc != n + 2 + i || wr_log[i].addr != 7 || wr_log[i].data !== e_d[i] || wr_log[i].sat !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_write[%0d]: cyc=%0d addr=%0d data=%0d, need cyc=%0d addr=7 data=%0d",
                             i, wr_log[i].cyc, wr_log[i].addr, wr_log[i].data, n + 2 + i, e_d[i]);
                end
            end
        end
    endtask

    task automatic test_alternate();
        int n;
        logic [15:0] e_d [3];
        e_d[0] = 16'd1; e_d[1] = 16'd2; e_d[2] = 16'd4;
        b_addr[0] = 10'd1; b_addr[1] = 10'd2; b_addr[2] = 10'd1;
        b_delta[0] = 16'd1; b_delta[1] = 16'd2; b_delta[2] = 16'd3;
        wr_log.delete();
        n = cyc;
        run_burst(3);
        total++;
        if (wr_log.size() != 3) begin
            bad++;
            $display("FAIL alt_count: got %0d writes, need 3", wr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wr_log[i].cyc != n + 2 + i || wr_log[i].addr != int'(b_addr[i]) || wr_log[i].data !== e_d[i]) begin
                    bad++;
                    $display("FAIL alt_write[%0d]: addr=%0d data=%0d, need addr=%0d data=%0d",
                             i, wr_log[i].addr, wr_log[i].data, b_addr[i], e_d[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] e_d [4];
        logic        e_s [4];
        b_addr[0] = 10'd3; b_addr[1] = 10'd3; b_addr[2] = 10'd4; b_addr[3] = 10'd4;
        b_delta[0] = 16'd32000; b_delta[1] = 16'd1000; b_delta[2] = 16'h8000; b_delta[3] = 16'hFFFF;
        e_d[0] = 16'd32000; e_d[1] = 16'h7FFF; e_d[2] = 16'h8000; e_d[3] = 16'h8000;
        e_s[0] = 1'b0; e_s[1] = 1'b1; e_s[2] = 1'b0; e_s[3] = 1'b1;
        wr_log.delete();
        run_burst(4);
        total++;
        if (wr_log.size() != 4) begin
            bad++;
            $display("FAIL sat_count: got %0d writes, need 4", wr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (wr_log[i].addr != int'(b_addr[i]) || wr_log[i].data !== e_d[i] || wr_log[i].sat !== e_s[i]) begin
                    bad++;
                    $display("FAIL sat_write[%0d]: addr=%0d data=%h sat=%b, need addr=%0d data=%h sat=%b",
                             i, wr_log[i].addr, wr_log[i].data, wr_log[i].sat, b_addr[i], e_d[i], e_s[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [9:0]  a;
        logic [15:0] d;
        wr_log.delete();
        exp_q.delete();
        mon_err = 0;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 3) != 0);
            a = 10'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       d = 16'($urandom_range(0, 15));
                1:       d = 16'h8000 | 16'($urandom_range(0, 255));
                2:       d = 16'h7F00 | 16'($urandom_range(0, 255));
                default: d = 16'($urandom);
            endcase
            drive_cycle(v, a, d, 1'b0);
            total++;
            if (obs_ready !== 1'b1) begin
                bad++;
                $display("FAIL rand_ready[%0d]: in_ready=%b, need 1", i, obs_ready);
            end
        end
        idle(4);
        total++;
        if (wr_log.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got %0d writes, need %0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (wr_log[i].cyc != exp_q[i].cyc || wr_log[i].addr != exp_q[i].addr ||
                    wr_log[i].data !== exp_q[i].data || wr_log[i].sat !== exp_q[i].sat) begin
                    bad++;
                    $display("FAIL rand_write[%0d]: cyc=%0d addr=%0d data=%h sat=%b, need cyc=%0d addr=%0d data=%h sat=%b",
                             i, wr_log[i].cyc, wr_log[i].addr, wr_log[i].data, wr_log[i].sat,
                             exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].sat);
                end
            end
        end
        total++;
        if (mon_err != 0) begin
            bad++;
            $display("FAIL upd_monitor: %0d cycles where upd_* differed from port B, need 0", mon_err);
        end
    endtask

    task automatic test_clr_drain();
        int n;
        wr_log.delete();
        n = cyc;
        drive_cycle(1'b1, 10'd10, 16'd5, 1'b0);
        drive_cycle(1'b1, 10'd11, 16'd6, 1'b0);
        drive_cycle(1'b1, 10'd12, 16'd7, 1'b1);
        total++;
        if (obs_ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_ready: in_ready=%b during clr, need 0", obs_ready);
        end
        idle(1);
        total++;
        if (obs_ready !== 1'b0 || obs_busy !== 1'b1) begin
            bad++;
            $display("FAIL drain_state: ready=%b busy=%b, need 0 1", obs_ready, obs_busy);
        end
        idle(1100);
        clear_model();
        total++;
        if (wr_log.size() != 2 + DEPTH) begin
            bad++;
            $display("FAIL drain_count: got %0d writes, need %0d", wr_log.size(), 2 + DEPTH);
        end else begin
            total++;
            if (wr_log[0].cyc != n + 2 || wr_log[0].addr != 10 || wr_log[0].data !== 16'd5 ||
                wr_log[1].cyc != n + 3 || wr_log[1].addr != 11 || wr_log[1].data !== 16'd6) begin
                bad++;
                $display("FAIL drain_inflight: %0d@%0d=%0d %0d@%0d=%0d, need 10@%0d=5 11@%0d=6",
                         wr_log[0].addr, wr_log[0].cyc, wr_log[0].data, wr_log[1].addr, wr_log[1].cyc,
                         wr_log[1].data, n + 2, n + 3);
            end
            for (int i = 0; i < DEPTH; i++) begin
                total++;
                if (wr_log[2 + i].addr != i || wr_log[2 + i].data !== 16'd0 || wr_log[2 + i].sat !== 1'b0 ||
                    wr_log[2 + i].cyc != wr_log[2].cyc + i) begin
                    bad++;
                    $display("FAIL drain_clear[%0d]: addr=%0d data=%h sat=%b, need addr=%0d data=0000 sat=0",
                             i, wr_log[2 + i].addr, wr_log[2 + i].data, wr_log[2 + i].sat, i);
                end
            end
        end
        total++;
        if (obs_ready !== 1'b1 || obs_busy !== 1'b0) begin
            bad++;
            $display("FAIL post_clear_run: ready=%b busy=%b, need 1 0", obs_ready, obs_busy);
        end
        wr_log.delete();
        n = cyc;
        drive_cycle(1'b1, 10'd5, 16'd1, 1'b0);
        idle(3);
        total++;
        if (wr_log.size() != 1 || wr_log[0].addr != 5 || wr_log[0].data !== 16'd1 || wr_log[0].cyc != n + 2) begin
            bad++;
            $display("FAIL post_clear_update: %0d writes, first data=%0d, need 1 write addr=5 data=1",
                     wr_log.size(), (wr_log.size() > 0) ? wr_log[0].data : 16'hFFFF);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                drive_cycle(1'b0, 10'd0, 16'd0, 1'b1);
                idle(502);
            end else begin
                drive_cycle(1'b1, 10'd20, 16'd50, 1'b0);
                drive_cycle(1'b1, 10'd21, 16'd60, 1'b0);
                drive_cycle(1'b1, 10'd20, 16'd70, 1'b0);
            end
            reset = 1'b1;
            idle(1);
            total++;
            if (obs_web !== 1'b0 || obs_busy !== 1'b1 || obs_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_abort[%0d]: web=%b busy=%b ready=%b, need 0 1 0", pass, obs_web, obs_busy, obs_ready);
            end
            idle(2);
            reset = 1'b0;
            wr_log.delete();
            clear_model();
            n = cyc;
            idle(1030);
            total++;
            if (wr_log.size() != DEPTH) begin
                bad++;
                $display("FAIL restart_count[%0d]: got %0d writes, need %0d", pass, wr_log.size(), DEPTH);
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    total++;
                    if (wr_log[i].addr != i || wr_log[i].data !== 16'd0 || wr_log[i].cyc != n + 1 + i) begin
                        bad++;
                        $display("FAIL restart_clear[%0d][%0d]: addr=%0d data=%h cyc=%0d, need addr=%0d data=0000 cyc=%0d",
                                 pass, i, wr_log[i].addr, wr_log[i].data, wr_log[i].cyc, i, n + 1 + i);
                    end
                end
            end
            total++;
            if (obs_ready !== 1'b1 || obs_busy !== 1'b0) begin
                bad++;
                $display("FAIL restart_run[%0d]: ready=%b busy=%b, need 1 0", pass, obs_ready, obs_busy);
            end
        end
        wr_log.delete();
        drive_cycle(1'b1, 10'd20, 16'd1, 1'b0);
        idle(3);
        total++;
        if (wr_log.size() != 1 || wr_log[0].addr != 20 || wr_log[0].data !== 16'd1) begin
            bad++;
            $display("FAIL post_reset_update: %0d writes, need 1 write addr=20 data=1", wr_log.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_addr = 10'd0; in_delta = 16'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_alternate();
        test_saturation();
        test_random();
        test_clr_drain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
